// File: rtl/div_unit_ctrl.sv
// ---------------------------------------------------------------------------
// div_unit_ctrl
// Multi-cycle sequencer for the RISC-V M-extension divide/remainder ops
// (DIV, DIVU, REM, REMU) in the EX stage. It uses a radix-2 restoring
// shift-subtract datapath that produces one quotient bit per cycle.
// Divide-by-zero and signed overflow take a fast path.
//
// Optional feature: define DIV_EARLY_OUT_EN so that any op with
// |op_a| < |op_b| skips the iteration and goes straight to the sign fix.
//
// Ports:
//   CLK     in   clock, rising edge
//   RESET   in   synchronous active-high reset
//   start   in   request a divide-class op (sampled in IDLE/DONE)
//   funct3  in   100=DIV 101=DIVU 110=REM 111=REMU; funct3[2]=0 ignored
//   op_a    in   dividend, captured on accept
//   op_b    in   divisor, captured on accept
//   flush   in   abort in-flight op
//   stall   out  freeze front-end pipeline registers
//   busy    out  high while iterating or fixing signs
//   done    out  one-cycle result-valid pulse
//   result  out  quotient/remainder, held until the next completion
// ---------------------------------------------------------------------------
module div_unit_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [5:0]       CNT_LAST = 6'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ALL_ONE  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       r_state;
  logic [5:0]       r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;     // dividend shifts out of the top, quotient in at the bottom
  logic [WIDTH-1:0] r_div;     // divisor magnitude
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_sel_rem;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;

  logic [1:0]       w_next;
  logic             w_accept;
  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_div0;
  logic             w_ovf;
  logic             w_early;
  logic [WIDTH:0]   w_rem_shift;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_sub;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  assign w_accept = start & funct3[2] & ~flush &
                    ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_signed = ~funct3[0];
  assign w_a_neg  = w_signed & op_a[WIDTH-1];
  assign w_b_neg  = w_signed & op_b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -op_a : op_a;
  assign w_b_mag  = w_b_neg ? -op_b : op_b;
  assign w_div0   = (op_b == ALL_ZERO);
  assign w_ovf    = w_signed & (op_a == MIN_NEG) & (op_b == ALL_ONE);

`ifdef DIV_EARLY_OUT_EN
  assign w_early  = (w_a_mag < w_b_mag);
`else
  assign w_early  = 1'b0;
`endif

  // The shifted partial remainder keeps its top bit. A divisor magnitude of
  // 2^(WIDTH-1) or more can leave a remainder whose shift overflows WIDTH bits.
  // After the step the result is always below the divisor, so WIDTH bits of
  // the difference are enough.
  assign w_rem_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_q_bit     = (w_rem_shift >= {1'b0, r_div});
  assign w_sub       = w_rem_shift[WIDTH-1:0] - r_div;
  assign w_rem_next  = w_q_bit ? w_sub : w_rem_shift[WIDTH-1:0];

  assign w_q_fix = r_neg_q ? -r_quo : r_quo;
  assign w_r_fix = r_neg_r ? -r_rem : r_rem;

  // Next-state selection for the sequencer
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          if (w_div0 | w_ovf) begin
            w_next = S_DONE;
          end else if (w_early) begin
            w_next = S_FIX;
          end else begin
            w_next = S_CALC;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_CALC: begin
        if (flush) begin
          w_next = S_IDLE;
        end else if (r_cnt == 6'd0) begin
          w_next = S_FIX;
        end else begin
          w_next = S_CALC;
        end
      end
      S_FIX: begin
        if (flush) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_cnt     <= 6'd0;
      r_rem     <= ALL_ZERO;
      r_quo     <= ALL_ZERO;
      r_div     <= ALL_ZERO;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_sel_rem <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= ALL_ZERO;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == S_CALC) | (w_next == S_FIX);
      r_done  <= (w_next == S_DONE);
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_sel_rem <= funct3[1];
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
            r_div     <= w_b_mag;
            r_cnt     <= CNT_LAST;
            if (w_div0) begin
              r_result <= funct3[1] ? op_a : ALL_ONE;
            end else if (w_ovf) begin
              r_result <= funct3[1] ? ALL_ZERO : MIN_NEG;
            end else if (w_early) begin
              r_quo <= ALL_ZERO;
              r_rem <= w_a_mag;
            end else begin
              r_quo <= w_a_mag;
              r_rem <= ALL_ZERO;
            end
          end
        end
        S_CALC: begin
          if (!flush) begin
            r_rem <= w_rem_next;
            r_quo <= {r_quo[WIDTH-2:0], w_q_bit};
            r_cnt <= r_cnt - 6'd1;
          end
        end
        S_FIX: begin
          if (!flush) begin
            r_result <= r_sel_rem ? w_r_fix : w_q_fix;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // stall must cover the accept cycle itself, so it includes the live accept term
  assign stall  = r_busy | w_accept;
  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_div_unit_ctrl.sv
module tb_div_unit_ctrl;
  logic        CLK = 1'b0;
  logic        RESET, start, flush;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        stall, busy, done;
  logic [31:0] result;

  always #5 CLK = ~CLK;

  div_unit_ctrl #(.WIDTH(32)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .stall(stall), .busy(busy), .done(done), .result(result)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: an op in flight with a number of cycles left to its done beat
  bit          m_inflight = 1'b0;
  int          m_left = 0;
  logic [31:0] m_pending = 32'd0;
  logic [31:0] m_res = 32'd0;
  int          acc_cyc = 0;
  int          done_cyc = -1;
  int          done_cnt = 0;

  function automatic logic [31:0] ref_div(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    longint sa, sb;
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!f3[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return f3[1] ? r : q;
  endfunction

  function automatic bit is_special(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    return (b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] mag(logic [2:0] f3, logic [31:0] x);
    return (!f3[0] && x[31]) ? -x : x;
  endfunction

  function automatic bit is_early(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    return (b != 32'd0) && (mag(f3, a) < mag(f3, b));
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive, compare at negedge, advance model, cross posedge
  task automatic step(bit r, bit s, logic [2:0] f, logic [31:0] a, logic [31:0] b,
                      bit fl, bit chk = 1'b1);
    bit e_busy, e_done, e_acc;
    RESET = r; start = s; funct3 = f; op_a = a; op_b = b; flush = fl;
    @(negedge CLK);
    e_busy = m_inflight && (m_left > 0);
    e_done = m_inflight && (m_left == 0);
    e_acc  = s && f[2] && !fl && !e_busy;
    if (chk) begin
      check("busy", {31'd0, busy}, {31'd0, e_busy});
      check("done", {31'd0, done}, {31'd0, e_done});
      check("stall", {31'd0, stall}, {31'd0, e_busy | e_acc});
      check("result", result, m_res);
    end
    if (done === 1'b1) begin
      done_cyc = cyc;
      done_cnt++;
    end
    if (r) begin
      m_inflight = 1'b0;
      m_res = 32'd0;
    end else if (e_busy && fl) begin
      m_inflight = 1'b0;
    end else if (e_acc) begin
      m_inflight = 1'b1;
      acc_cyc    = cyc;
      m_pending  = ref_div(f, a, b);
      m_left     = is_special(f, a, b) ? 0 : (is_early(f, a, b) ? 1 : 33);
    end else if (m_inflight) begin
      if (m_left == 0) m_inflight = 1'b0;
      else m_left--;
    end
    if (!r && m_inflight && m_left == 0) m_res = m_pending;
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic run_op(string nm, logic [2:0] f, logic [31:0] a, logic [31:0] b,
                        logic [31:0] exp_res, int exp_lat);
    int d0;
    d0 = done_cnt;
    step(1'b0, 1'b1, f, a, b, 1'b0);
    idle(40);
    check({nm, "_cnt"}, done_cnt - d0, 1);
    check({nm, "_lat"}, done_cyc - acc_cyc, exp_lat);
    check({nm, "_res"}, result, exp_res);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int d0, t_acc;
    int early_lat;
    // Hand-computed anchors for the reference model
    check("pin_div", ref_div(3'b100, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    check("pin_rem", ref_div(3'b110, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    check("pin_remu", ref_div(3'b111, 32'd7, 32'd2), 32'd1);
    check("pin_divu", ref_div(3'b101, 32'hFFFF_FFFF, 32'h10), 32'h0FFF_FFFF);
    check("pin_ovf", ref_div(3'b100, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    check("pin_div0", ref_div(3'b101, 32'd100, 32'd0), 32'hFFFF_FFFF);

    step(1'b1, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    idle(2);

    run_op("div_m7_2",  3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run_op("rem_m7_2",  3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run_op("remu_7_2",  3'b111, 32'd7, 32'd2, 32'd1, 34);
    run_op("divu_big",  3'b101, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 34);
    run_op("divu_z",    3'b101, 32'd100, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("rem_z",     3'b110, 32'd100, 32'd0, 32'd100, 1);
    run_op("div_ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
`ifdef DIV_EARLY_OUT_EN
    early_lat = 2;
`else
    early_lat = 34;
`endif
    run_op("div_3_7",   3'b100, 32'd3, 32'd7, 32'd0, early_lat);

    // Flush mid-calculation, then a fresh op
    d0 = done_cnt;
    step(1'b0, 1'b1, 3'b101, 32'd20, 32'd3, 1'b0);
    idle(9);
    step(1'b0, 1'b1, 3'b101, 32'd20, 32'd3, 1'b1);
    step(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    check("flush_nodone", done_cnt - d0, 0);
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_res", result, 32'd0);
    run_op("after_flush", 3'b101, 32'd20, 32'd3, 32'd6, 34);

    // Back-to-back: second accept in the DONE cycle of the first
    d0 = done_cnt;
    step(1'b0, 1'b1, 3'b101, 32'd20, 32'd3, 1'b0);
    idle(33);
    t_acc = cyc;
    step(1'b0, 1'b1, 3'b101, 32'd9, 32'd4, 1'b0);
    check("b2b_first", done_cyc, t_acc);
    idle(40);
    check("b2b_cnt", done_cnt - d0, 2);
    check("b2b_lat", done_cyc - t_acc, 34);
    check("b2b_res", result, 32'd2);

    // Reset mid-calculation
    step(1'b0, 1'b1, 3'b101, 32'd1000, 32'd7, 1'b0);
    idle(4);
    step(1'b1, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    check("rst_res", result, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    idle(3);

    // Randomized traffic against the model
    for (int i = 0; i < 6000; i++) begin
      step($urandom_range(0, 999) == 0, $urandom_range(0, 3) != 0,
           3'($urandom), pick(), pick(), $urandom_range(0, 39) == 0);
    end
    idle(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
